memory_stage_ext: RTL and testbench

// - Next-generation MEM stage of the pipelined RV32 core: internal data RAM plus M->W pipeline register.
// - Adds byte/halfword loads and stores with sign/zero extension, a configurable RAM wait-state count

---
 rtl/memory_stage_ext_if.sv | 40 ++++
 rtl/memory_stage_ext.sv | 166 ++++++++++++++++
 tb/tb_memory_stage_ext.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_ext_if.sv
// Bundle between the execute stage (master) and the MEM stage (slave): M-side inputs, W-side results,
// the stall back to the hazard unit, and the MEM-stage FSM state for observation.
interface memory_stage_ext_if;
    logic        RegWriteM;
    logic        MemReadM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [2:0]  Funct3M;
    logic        FlushW;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    logic        StallM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic        FaultW;
    logic        state_dbg;

    // Handshake: while StallM=1 the master holds every M-side field stable; the access
    // completes at the first rising edge where StallM=0, and W reflects it after that edge.
    modport master (
        output RegWriteM, MemReadM, MemWriteM, ResultSrcM, Funct3M, FlushW,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        input  StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, FaultW, state_dbg
    );

    modport slave (
        input  RegWriteM, MemReadM, MemWriteM, ResultSrcM, Funct3M, FlushW,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        output StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, FaultW, state_dbg
    );
endinterface

// File: rtl/memory_stage_ext.sv
// RV32 MEM stage: byte-enabled data RAM with optional wait states, load extension,
// access-fault detection and the M->W pipeline register.
module memory_stage_ext #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input logic               clk,
    input logic               rst,
    memory_stage_ext_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          state, state_next;
    logic [2:0]      cnt, cnt_next;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [AW-1:0]   index;
    logic            access, illegal, misaligned, fault;
    logic            stall, complete, write_en;
    logic [3:0]      byte_en;
    logic [XLEN-1:0] wdata, rword, load_data, read_value;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    assign index  = bus.ALU_ResultM[AW+1:2];
    assign access = bus.MemReadM | bus.MemWriteM;

    // Unsigned encodings only exist for loads; anything outside B/H/W/BU/HU faults.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (bus.Funct3M)
            3'b000: misaligned = 1'b0;
            3'b001: misaligned = bus.ALU_ResultM[0];
            3'b010: misaligned = |bus.ALU_ResultM[1:0];
            3'b100: illegal    = bus.MemWriteM;
            3'b101: begin
                illegal    = bus.MemWriteM;
                misaligned = bus.ALU_ResultM[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = access & (illegal | misaligned);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A flush overrides completion and abandons any access in flight.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (access && !fault && (WAIT_CYCLES != 0)) begin
                    stall      = 1'b1;
                    state_next = S_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt != 3'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt - 3'd1;
                end else begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (bus.FlushW) begin
            state_next = S_IDLE;
            cnt_next   = 3'd0;
        end
    end

    assign bus.StallM    = stall;
    assign bus.state_dbg = (state == S_WAIT);
    assign write_en      = complete & bus.MemWriteM & ~fault & ~bus.FlushW;

    always_comb begin
        case (bus.Funct3M[1:0])
            2'b00: begin
                byte_en = 4'b0001 << bus.ALU_ResultM[1:0];
                wdata   = {4{bus.WriteDataM[7:0]}};
            end
            2'b01: begin
                byte_en = bus.ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.WriteDataM[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = bus.WriteDataM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read is taken from the array before the edge, so a combined read+write returns old data.
    assign rword  = mem[index];
    assign lane_b = rword[8*bus.ALU_ResultM[1:0] +: 8];
    assign lane_h = bus.ALU_ResultM[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (bus.Funct3M)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_data = rword;
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = '0;
        endcase
    end

    assign read_value = (bus.MemReadM && !fault) ? load_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= 5'd0;
            bus.PCPlus4W    <= '0;
            bus.ALU_ResultW <= '0;
            bus.ReadDataW   <= '0;
            bus.FaultW      <= 1'b0;
        end else begin
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.PCPlus4W    <= bus.PCPlus4M;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            if (bus.FlushW || !complete) begin
                bus.RegWriteW <= 1'b0;
                bus.FaultW    <= 1'b0;
                bus.ReadDataW <= '0;
            end else begin
                bus.RegWriteW <= bus.RegWriteM & ~fault;
                bus.FaultW    <= fault;
                bus.ReadDataW <= read_value;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage_ext.sv
// Bench for memory_stage_ext: a zero-wait and a three-wait instance share one driver, checked
// against a byte-addressed reference memory with directed and randomized accesses.
module tb_memory_stage_ext;
    localparam int DEPTH  = 1024;
    localparam int NBYTES = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_ext_if if0 ();
    memory_stage_ext_if if3 ();

    memory_stage_ext #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    memory_stage_ext #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave)
    );

    logic        sel3;
    logic        m_rw, m_mr, m_mw, m_rs, m_flush;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [31:0] m_pc, m_wd, m_a;

    assign if0.RegWriteM   = sel3 ? 1'b0  : m_rw;
    assign if0.MemReadM    = sel3 ? 1'b0  : m_mr;
    assign if0.MemWriteM   = sel3 ? 1'b0  : m_mw;
    assign if0.ResultSrcM  = sel3 ? 1'b0  : m_rs;
    assign if0.Funct3M     = sel3 ? 3'd0  : m_f3;
    assign if0.FlushW      = sel3 ? 1'b0  : m_flush;
    assign if0.RD_M        = sel3 ? 5'd0  : m_rd;
    assign if0.PCPlus4M    = sel3 ? 32'd0 : m_pc;
    assign if0.WriteDataM  = sel3 ? 32'd0 : m_wd;
    assign if0.ALU_ResultM = sel3 ? 32'd0 : m_a;

    assign if3.RegWriteM   = sel3 ? m_rw    : 1'b0;
    assign if3.MemReadM    = sel3 ? m_mr    : 1'b0;
    assign if3.MemWriteM   = sel3 ? m_mw    : 1'b0;
    assign if3.ResultSrcM  = sel3 ? m_rs    : 1'b0;
    assign if3.Funct3M     = sel3 ? m_f3    : 3'd0;
    assign if3.FlushW      = sel3 ? m_flush : 1'b0;
    assign if3.RD_M        = sel3 ? m_rd    : 5'd0;
    assign if3.PCPlus4M    = sel3 ? m_pc    : 32'd0;
    assign if3.WriteDataM  = sel3 ? m_wd    : 32'd0;
    assign if3.ALU_ResultM = sel3 ? m_a     : 32'd0;

    logic        o_stall, o_rw, o_rs, o_fault, o_state;
    logic [4:0]  o_rd;
    logic [31:0] o_pc, o_alu, o_data;

    assign o_stall = sel3 ? if3.StallM      : if0.StallM;
    assign o_rw    = sel3 ? if3.RegWriteW   : if0.RegWriteW;
    assign o_rs    = sel3 ? if3.ResultSrcW  : if0.ResultSrcW;
    assign o_fault = sel3 ? if3.FaultW      : if0.FaultW;
    assign o_state = sel3 ? if3.state_dbg   : if0.state_dbg;
    assign o_rd    = sel3 ? if3.RD_W        : if0.RD_W;
    assign o_pc    = sel3 ? if3.PCPlus4W    : if0.PCPlus4W;
    assign o_alu   = sel3 ? if3.ALU_ResultW : if0.ALU_ResultW;
    assign o_data  = sel3 ? if3.ReadDataW   : if0.ReadDataW;

    logic [7:0]  mb [2][NBYTES];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data;
    logic        last_rw, last_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic [2:0] f3, input logic mw, input logic [31:0] a);
        logic legal;
        int   size;
        legal = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !mw);
        size  = 1 << f3[1:0];
        return !legal || ((a & 32'(size - 1)) != 32'd0);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] a);
        int          n, base;
        logic [31:0] v;
        n    = 1 << f3[1:0];
        base = int'(a % NBYTES);
        v    = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[d][base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n, base;
        n    = 1 << f3[1:0];
        base = int'(a % NBYTES);
        for (int i = 0; i < n; i++) mb[d][base + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    task automatic drive_idle();
        m_rw = 0; m_mr = 0; m_mw = 0; m_rs = 0; m_flush = 0;
        m_f3 = 3'd0; m_rd = 5'd0; m_pc = 32'd0; m_wd = 32'd0; m_a = 32'd0;
    endtask

    // One instruction through the selected instance: count stall cycles, check bubbles, then W.
    task automatic issue(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          d, n, exp_stall;
        logic        flt;
        logic [31:0] exp_data;
        d = sel3 ? 1 : 0;
        m_rw = rw; m_mr = mr; m_mw = mw; m_f3 = f3; m_a = a; m_wd = wd; m_flush = 0;
        m_rs = 1'($urandom_range(0, 1));
        m_rd = 5'($urandom_range(0, 31));
        m_pc = $urandom;
        flt       = (mr | mw) && model_fault(f3, mw, a);
        exp_data  = (mr && !flt) ? model_load(d, f3, a) : 32'd0;
        exp_stall = ((mr | mw) && !flt) ? (sel3 ? 3 : 0) : 0;
        #1;
        n = 0;
        while (o_stall === 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk({tag, " bubble_rw"}, 32'(o_rw), 32'd0);
            chk({tag, " bubble_fault"}, 32'(o_fault), 32'd0);
            n++;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
        if (mw && !flt) model_store(d, f3, a, wd);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, " rw"}, 32'(o_rw), 32'(rw && !flt));
        chk({tag, " fault"}, 32'(o_fault), 32'(flt));
        chk({tag, " data"}, o_data, exp_data);
        chk({tag, " rd"}, 32'(o_rd), 32'(m_rd));
        chk({tag, " pc"}, o_pc, m_pc);
        chk({tag, " alu"}, o_alu, m_a);
        chk({tag, " rs"}, 32'(o_rs), 32'(m_rs));
        last_data  = o_data;
        last_rw    = o_rw;
        last_fault = o_fault;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, " rw"}, 32'(o_rw), 32'd0);
        chk({tag, " rs"}, 32'(o_rs), 32'd0);
        chk({tag, " rd"}, 32'(o_rd), 32'd0);
        chk({tag, " pc"}, o_pc, 32'd0);
        chk({tag, " alu"}, o_alu, 32'd0);
        chk({tag, " data"}, o_data, 32'd0);
        chk({tag, " fault"}, 32'(o_fault), 32'd0);
        chk({tag, " stall"}, 32'(o_stall), 32'd0);
        chk({tag, " state"}, 32'(o_state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic        rw, mr, mw;
        logic [31:0] a;
        int          k;

        sel3 = 0;
        drive_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk_w_zero("reset0");
        sel3 = 1;
        #1;
        chk_w_zero("reset3");
        rst = 0;

        // Both RAMs start unknown; seed words 0..15 before anything reads them.
        for (int s = 0; s < 2; s++) begin
            sel3 = (s == 1);
            for (int w = 0; w < 16; w++) issue(0, 0, 1, 3'd2, 32'(4 * w), $urandom, "init_sw");
        end

        sel3 = 0;
        issue(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_deadbeef");
        issue(1, 1, 0, 3'd2, 32'h10, 32'd0, "lw_deadbeef");
        chk("lw_deadbeef const", last_data, 32'hDEADBEEF);

        issue(0, 0, 1, 3'd2, 32'h10, 32'h11223344, "sw_base");
        issue(0, 0, 1, 3'd0, 32'h13, 32'h00000080, "sb_13");
        issue(1, 1, 0, 3'd2, 32'h10, 32'd0, "lw_after_sb");
        chk("lw_after_sb const", last_data, 32'h80223344);
        issue(1, 1, 0, 3'd0, 32'h13, 32'd0, "lb_13");
        chk("lb_13 const", last_data, 32'hFFFFFF80);
        issue(1, 1, 0, 3'd4, 32'h13, 32'd0, "lbu_13");
        chk("lbu_13 const", last_data, 32'h00000080);

        issue(0, 0, 1, 3'd2, 32'h10, 32'h80015555, "sw_half");
        issue(1, 1, 0, 3'd1, 32'h12, 32'd0, "lh_12");
        chk("lh_12 const", last_data, 32'hFFFF8001);
        issue(1, 1, 0, 3'd5, 32'h12, 32'd0, "lhu_12");
        chk("lhu_12 const", last_data, 32'h00008001);
        issue(1, 1, 0, 3'd1, 32'h11, 32'd0, "lh_11_misaligned");
        chk("lh_11 fault const", 32'(last_fault), 32'd1);
        chk("lh_11 rw const", 32'(last_rw), 32'd0);
        issue(0, 0, 1, 3'd4, 32'h10, 32'hFFFFFFFF, "sbu_illegal");
        issue(0, 0, 1, 3'd1, 32'h11, 32'hFFFFFFFF, "sh_misaligned");
        issue(0, 0, 1, 3'd2, 32'h12, 32'hFFFFFFFF, "sw_misaligned");
        issue(1, 1, 0, 3'd2, 32'h10, 32'd0, "lw_unchanged");
        chk("lw_unchanged const", last_data, 32'h80015555);

        issue(0, 0, 1, 3'd2, 32'h14, 32'h01020304, "sw_pre");
        issue(1, 1, 1, 3'd2, 32'h14, 32'hCAFEF00D, "rw_combined");
        chk("rw_combined old const", last_data, 32'h01020304);
        issue(1, 1, 0, 3'd2, 32'h14, 32'd0, "lw_combined");
        chk("lw_combined const", last_data, 32'hCAFEF00D);

        issue(0, 0, 1, 3'd2, 32'h1000, 32'h0BADF00D, "sw_alias");
        issue(1, 1, 0, 3'd2, 32'h0, 32'd0, "lw_alias");
        chk("lw_alias const", last_data, 32'h0BADF00D);
        issue(1, 0, 0, 3'd2, 32'h12345678, 32'd0, "alu_op");

        m_rw = 1; m_mr = 1; m_mw = 0; m_f3 = 3'd2; m_a = 32'h10; m_flush = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("flush0 rw", 32'(o_rw), 32'd0);
        chk("flush0 fault", 32'(o_fault), 32'd0);
        drive_idle();

        sel3 = 1;
        issue(1, 1, 0, 3'd2, 32'h8, 32'd0, "w3_lw");
        issue(0, 0, 1, 3'd2, 32'h8, 32'h12345678, "w3_sw");
        issue(1, 1, 0, 3'd2, 32'h8, 32'd0, "w3_lw_back");
        chk("w3_lw_back const", last_data, 32'h12345678);

        m_rw = 0; m_mr = 0; m_mw = 1; m_f3 = 3'd2; m_a = 32'h8; m_wd = 32'hFFFFFFFF; m_flush = 0;
        #1;
        chk("w3_flush idle_stall", 32'(o_stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("w3_flush wait1_stall", 32'(o_stall), 32'd1);
        chk("w3_flush wait1_state", 32'(o_state), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_flush = 1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
        chk("w3_flush stall_after", 32'(o_stall), 32'd0);
        chk("w3_flush state_after", 32'(o_state), 32'd0);
        chk("w3_flush rw_after", 32'(o_rw), 32'd0);
        issue(1, 1, 0, 3'd2, 32'h8, 32'd0, "w3_lw_after_flush");
        chk("w3_lw_after_flush const", last_data, 32'h12345678);

        issue(1, 1, 0, 3'd2, 32'h0, 32'd0, "w3_lw_before_rst");
        m_rw = 0; m_mr = 0; m_mw = 1; m_f3 = 3'd2; m_a = 32'h0; m_wd = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        drive_idle();
        #1;
        chk_w_zero("w3_rst_mid_wait");
        issue(1, 1, 0, 3'd2, 32'h1000, 32'd0, "w3_lw_alias_after_rst");

        // Randomized traffic on both instances over the seeded window, upper address bits noisy.
        for (int s = 0; s < 2; s++) begin
            sel3 = (s == 1);
            for (int i = 0; i < 40; i++) begin
                k  = int'($urandom_range(0, 9));
                f3 = (k > 7) ? 3'd2 : 3'(k);
                k  = int'($urandom_range(0, 5));
                rw = 1'($urandom_range(0, 1));
                mr = (k == 1 || k == 2 || k == 5);
                mw = (k == 3 || k == 4 || k == 5);
                a  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << 12);
                issue(rw, mr, mw, f3, a, $urandom, "random");
            end
        end
        drive_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
